apple_1_bus_arbiter: RTL and testbench

//  Shares the Apple-I memory port between the 6502 core and a host debug/loader port.

---
 rtl/apple_1_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_apple_1_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apple_1_bus_arbiter.sv
// Shares the Apple-I RAM port between the 6502 core and a host debug/loader port.
// Host accesses stall the CPU through RDY; the CPU's pending read data is held across the stall.
module apple_1_bus_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int HOST_BURST = 4,
  parameter int CPU_GAP    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_rdy,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_CPU    = 3'd0,
    S_STALL  = 3'd1,
    S_H_ADDR = 3'd2,
    S_H_DATA = 3'd3,
    S_H_ACK  = 3'd4,
    S_H_GAP  = 3'd5,
    S_RESUME = 3'd6
  } state_t;

  localparam int BW = (HOST_BURST > 1) ? $clog2(HOST_BURST) : 1;
  localparam int GW = $clog2(CPU_GAP + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(HOST_BURST - 1);
  localparam logic [GW-1:0] GAP_INIT   = GW'(CPU_GAP);

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]   cpu_di_hold_q, cpu_di_hold_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;
  logic            host_ack_q, host_ack_d;
  logic            cpu_rdy_q, cpu_rdy_d;
  logic            host_busy_q, host_busy_d;
  logic            hreq_we_q, hreq_we_d;
  logic [AW-1:0]   hreq_addr_q, hreq_addr_d;
  logic [DW-1:0]   hreq_wdata_q, hreq_wdata_d;
  logic            gap_done_s;

  // The CPU cycle in which the count reaches zero is itself the last required gap cycle.
  assign gap_done_s = (gap_cnt_q <= GW'(1));

  // State, counters, latched host request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CPU;
      burst_cnt_q   <= '0;
      gap_cnt_q     <= GAP_INIT;
      cpu_di_hold_q <= '0;
      host_rdata_q  <= '0;
      host_ack_q    <= 1'b0;
      cpu_rdy_q     <= 1'b1;
      host_busy_q   <= 1'b0;
      hreq_we_q     <= 1'b0;
      hreq_addr_q   <= '0;
      hreq_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      cpu_di_hold_q <= cpu_di_hold_d;
      host_rdata_q  <= host_rdata_d;
      host_ack_q    <= host_ack_d;
      cpu_rdy_q     <= cpu_rdy_d;
      host_busy_q   <= host_busy_d;
      hreq_we_q     <= hreq_we_d;
      hreq_addr_q   <= hreq_addr_d;
      hreq_wdata_q  <= hreq_wdata_d;
    end
  end

  // Next-state logic; output registers are decoded from the next state.
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    cpu_di_hold_d = cpu_di_hold_q;
    host_rdata_d  = host_rdata_q;
    hreq_we_d     = hreq_we_q;
    hreq_addr_d   = hreq_addr_q;
    hreq_wdata_d  = hreq_wdata_q;
    case (state_q)
      S_CPU: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end else begin
          gap_cnt_d = '0;
        end
        if (host_req && gap_done_s) begin
          state_d = S_STALL;
        end else begin
          state_d = S_CPU;
        end
      end
      S_STALL: begin
        cpu_di_hold_d = mem_rdata;
        burst_cnt_d   = '0;
        hreq_we_d     = host_we;
        hreq_addr_d   = host_addr;
        hreq_wdata_d  = host_wdata;
        state_d       = S_H_ADDR;
      end
      S_H_ADDR: begin
        state_d = S_H_DATA;
      end
      S_H_DATA: begin
        if (!hreq_we_q) begin
          host_rdata_d = mem_rdata;
        end else begin
          host_rdata_d = host_rdata_q;
        end
        state_d = S_H_ACK;
      end
      S_H_ACK: begin
        // A host that drops req while seeing ack ends the grant without a gap cycle.
        if ((burst_cnt_q == BURST_LAST) || !host_req) begin
          state_d = S_RESUME;
        end else begin
          state_d = S_H_GAP;
        end
      end
      S_H_GAP: begin
        if (host_req) begin
          state_d      = S_H_ADDR;
          burst_cnt_d  = burst_cnt_q + BW'(1);
          hreq_we_d    = host_we;
          hreq_addr_d  = host_addr;
          hreq_wdata_d = host_wdata;
        end else begin
          state_d = S_RESUME;
        end
      end
      S_RESUME: begin
        gap_cnt_d = GAP_INIT;
        state_d   = S_CPU;
      end
      default: begin
        state_d = S_CPU;
      end
    endcase
    host_ack_d  = (state_d == S_H_ACK);
    cpu_rdy_d   = (state_d == S_CPU);
    host_busy_d = (state_d != S_CPU);
  end

  // Memory bus steering; only the CPU state may pass cpu_we through.
  always_comb begin
    mem_addr  = cpu_ab;
    mem_wdata = cpu_do;
    mem_we    = 1'b0;
    cpu_di    = cpu_di_hold_q;
    case (state_q)
      S_CPU: begin
        mem_we = cpu_we;
        cpu_di = mem_rdata;
      end
      S_H_ADDR: begin
        mem_addr  = hreq_addr_q;
        mem_wdata = hreq_wdata_q;
        mem_we    = hreq_we_q;
      end
      S_H_DATA, S_H_ACK, S_H_GAP: begin
        mem_addr  = hreq_addr_q;
        mem_wdata = hreq_wdata_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_busy  = host_busy_q;

endmodule

// File: tb/tb_apple_1_bus_arbiter.sv
// Scoreboarded bench: host read data is queued at request time and checked by a monitor on each ack.
module tb_apple_1_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          rdy_low_cnt = 0;
  int          ack_cnt = 0;
  int          wr400_cnt = 0;

  always #5 clk = ~clk;

  apple_1_bus_arbiter #(.AW(16), .DW(8), .HOST_BURST(4), .CPU_GAP(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_busy(host_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM model (read-before-write) plus cycle counters.
  always @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    if (!cpu_rdy) rdy_low_cnt <= rdy_low_cnt + 1;
    if (host_ack) ack_cnt <= ack_cnt + 1;
    if (mem_we && mem_addr == 16'h0400) wr400_cnt <= wr400_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic host_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input logic [7:0] hold, input logic drop_early);
    int lat, snap, n;
    bit got;
    repeat (3) @(negedge clk);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    exp_q.push_back(exp_rd);
    snap = rdy_low_cnt;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (drop_early && lat == 2) begin
        host_req = 1'b0; host_addr = 16'h0200; host_wdata = 8'hFF; host_we = ~we;
      end
      if (!cpu_rdy && lat >= 2) chk("cpu_di_hold", 32'(cpu_di), 32'(hold));
      if (host_ack) got = 1'b1;
    end
    chk("ack_latency", 32'(lat), 32'd4);
    host_req = 1'b0;
    n = 0;
    while (!cpu_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_low_cycles", 32'(rdy_low_cnt - snap), 32'd5);
    chk("busy_after", 32'(host_busy), 32'd0);
  endtask

  initial begin
    int n, k, hi, snap, ack0;
    int t[6];
    bit got;

    fork
      forever begin
        @(negedge clk);
        if (host_ack === 1'b1) begin
          if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
          else chk("host_rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
        end
      end
    join_none

    reset = 1'b1; cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
    ld_we = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
    @(negedge clk);
    load(16'h0200, 8'h5A);
    load(16'h0300, 8'h00);
    load(16'h0400, 8'hEE);
    load(16'h0500, 8'h00);
    load(16'h0600, 8'h00);
    for (int i = 0; i < 6; i++) load(16'h0010 + 16'(i), 8'h10 + 8'(i) * 8'h11);

    chk("reset_rdy", 32'(cpu_rdy), 32'd1);
    chk("reset_ack", 32'(host_ack), 32'd0);
    chk("reset_rdata", 32'(host_rdata), 32'd0);
    chk("reset_busy", 32'(host_busy), 32'd0);
    reset = 1'b0;

    // CPU LDA $0200
    repeat (2) @(negedge clk);
    cpu_ab = 16'h0200;
    @(negedge clk);
    chk("cpu_read_0200", 32'(cpu_di), 32'h5A);
    chk("cpu_rdy_idle", 32'(cpu_rdy), 32'd1);

    // host write, host read, host read with req dropped in H_ADDR
    host_txn(1'b1, 16'h0300, 8'hA5, 8'h00, 8'h5A, 1'b0);
    host_txn(1'b0, 16'h0300, 8'h00, 8'hA5, 8'h5A, 1'b0);
    host_txn(1'b0, 16'h0300, 8'h00, 8'hA5, 8'h5A, 1'b1);

    // burst of 6 reads with req held high
    repeat (3) @(negedge clk);
    ack0 = ack_cnt; k = 0; hi = 0; n = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    exp_q.push_back(8'h10);
    while (k < 6 && n < 80) begin
      @(negedge clk);
      n++;
      if (cpu_rdy) hi++;
      if (host_ack) begin
        t[k] = n;
        k++;
        if (k < 6) begin
          host_addr = 16'h0010 + 16'(k);
          exp_q.push_back(8'h10 + 8'(k) * 8'h11);
        end else begin
          host_req = 1'b0;
        end
      end
    end
    host_req = 1'b0;
    chk("burst_acks", 32'(k), 32'd6);
    chk("burst_cpu_gap", 32'(hi), 32'd2);
    if (k == 6) begin
      chk("burst_first_ack", 32'(t[0]), 32'd4);
      chk("burst_spacing", 32'(t[1] - t[0]), 32'd4);
      chk("burst_resume_gap", 32'(t[4] - t[3]), 32'd7);
      chk("burst_spacing2", 32'(t[5] - t[4]), 32'd4);
    end
    n = 0;
    while (!cpu_rdy && n < 20) begin @(negedge clk); n++; end
    chk("burst_ack_count", 32'(ack_cnt - ack0), 32'd6);

    // CPU write $0400 in the cycle host_req rises
    repeat (3) @(negedge clk);
    snap = wr400_cnt;
    cpu_ab = 16'h0400; cpu_do = 8'h11; cpu_we = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0400; host_wdata = 8'h00;
    exp_q.push_back(8'h11);
    @(negedge clk);
    chk("stall_entered", 32'(cpu_rdy), 32'd0);
    cpu_we = 1'b0; cpu_do = 8'h00;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!cpu_rdy) chk("cpu_di_hold_wr", 32'(cpu_di), 32'hEE);
      if (host_ack) got = 1'b1;
    end
    chk("wr_ack_latency", 32'(n), 32'd3);
    host_req = 1'b0;
    n = 0;
    while (!cpu_rdy && n < 20) begin @(negedge clk); n++; end
    chk("cpu_di_after_resume", 32'(cpu_di), 32'h11);
    chk("write_once", 32'(wr400_cnt - snap), 32'd1);
    cpu_ab = 16'h0200;

    // reset asserted in H_DATA
    repeat (3) @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0500; host_wdata = 8'h77;
    repeat (3) @(negedge clk);
    chk("busy_in_hdata", 32'(host_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hdata_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_hdata_busy", 32'(host_busy), 32'd0);
    chk("rst_hdata_ack", 32'(host_ack), 32'd0);
    reset = 1'b0; host_req = 1'b0;

    // reset asserted in H_ADDR: the write issued that cycle still lands
    repeat (3) @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0600; host_wdata = 8'h99;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_haddr_busy", 32'(host_busy), 32'd0);
    chk("rst_haddr_rdy", 32'(cpu_rdy), 32'd1);
    reset = 1'b0; host_req = 1'b0;

    repeat (6) @(negedge clk);
    chk("ram_0600", 32'(ram[16'h0600]), 32'h99);
    chk("ram_0500", 32'(ram[16'h0500]), 32'h77);
    chk("ram_0300", 32'(ram[16'h0300]), 32'hA5);
    chk("ram_0200", 32'(ram[16'h0200]), 32'h5A);
    chk("ram_0400", 32'(ram[16'h0400]), 32'h11);
    chk("rdata_after_reset", 32'(host_rdata), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
